// File: rtl/bch_dec_enc_seq.sv
// ---------------------------------------------------------------------------------------------
// bch_dec_enc_seq
//   Sequential systematic encoder for a shortened double-error-correcting BCH code. A data
//   word is accepted over a valid/ready handshake. Its check bits are computed by an LFSR that
//   absorbs P_BPC data bits per cycle, MSB first. The codeword {data_o, ecc_o} is then held on
//   an output valid/ready handshake until downstream takes it.
//
//   Check bits = data(x) * x^2m mod g(x), g = m1*m3. data_i[P_D_WIDTH-1] is the highest-order
//   coefficient.
//
//   Optional feature macro: BCH_ENC_OVERALL_PAR_EN
//     defined   : ecc_o gains a top bit holding even parity over data and BCH check bits
//                 (DEC-TED). LP_CHK_W = 2m+1.
//     undefined : LP_CHK_W = 2m, no parity logic.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   data_i       data word to encode
//   in_valid_i   data_i valid
//   in_ready_o   encoder can accept a word (idle and not in reset)
//   data_o       registered copy of the accepted word
//   ecc_o        check bits (LP_CHK_W wide)
//   out_valid_o  data_o/ecc_o valid, held until out_ready_i
//   out_ready_i  downstream accepts the result
//   busy_o       encoder not idle
// ---------------------------------------------------------------------------------------------

package bch_dec_enc_seq_pkg;

    // Smallest field order m in 5..8 with 2^m-1 >= data width + 2m; 0 if none fits.
    function automatic int fn_field_order(int dw);
        int m;
        m = 0;
        for (int k = 8; k >= 5; k--) begin
            if (((2 ** k) - 1) >= (dw + 2 * k)) begin
                m = k;
            end
        end
        return m;
    endfunction

    function automatic int fn_ecc_synd_width(int dw);
`ifdef BCH_ENC_OVERALL_PAR_EN
        return 2 * fn_field_order(dw) + 1;
`else
        return 2 * fn_field_order(dw);
`endif
    endfunction

    // Primitive polynomial m1(x) for each supported field order, including the x^m term.
    function automatic logic [8:0] fn_prim(int m);
        logic [8:0] p;
        case (m)
            5:       p = 9'h025;
            6:       p = 9'h043;
            7:       p = 9'h089;
            8:       p = 9'h11D;
            default: p = 9'h000;
        endcase
        return p;
    endfunction

    // Multiplication in GF(2^m) modulo prim.
    function automatic logic [7:0] fn_gf_mul(logic [7:0] a, logic [7:0] b, int m,
                                             logic [8:0] prim);
        logic [8:0] acc_a;
        logic [7:0] res;
        acc_a = {1'b0, a};
        res   = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                res = res ^ acc_a[7:0];
            end
            acc_a = acc_a << 1;
            if ((acc_a & (9'd1 << m)) != 9'd0) begin
                acc_a = acc_a ^ prim;
            end
        end
        return res;
    endfunction

    // Generator g = m1 * m3. m3 is built as the product of (x + beta^(2^k)) over the conjugates
    // of beta = alpha^3; its coefficients land in GF(2).
    function automatic logic [16:0] fn_gen_poly(int m);
        logic [8:0]       prim;
        logic [8:0][7:0]  c;
        logic [7:0]       r;
        logic [8:0]       m3;
        logic [16:0]      g;
        prim = fn_prim(m);
        c    = '0;
        c[0] = 8'd1;
        r    = 8'h08;
        for (int k = 0; k < 8; k++) begin
            if (k < m) begin
                for (int j = 8; j >= 1; j--) begin
                    c[j] = c[j-1] ^ fn_gf_mul(c[j], r, m, prim);
                end
                c[0] = fn_gf_mul(c[0], r, m, prim);
                r    = fn_gf_mul(r, r, m, prim);
            end
        end
        for (int j = 0; j < 9; j++) begin
            m3[j] = c[j][0];
        end
        g = '0;
        for (int i = 0; i < 9; i++) begin
            if (prim[i]) begin
                g = g ^ ({8'b0, m3} << i);
            end
        end
        case (m)
            5:       g = 17'h00769;
            6:       g = 17'h01539;
            default: ;
        endcase
        return g;
    endfunction

endpackage

module bch_dec_enc_seq
    import bch_dec_enc_seq_pkg::*;
#(
    parameter  int unsigned P_D_WIDTH = 16,
    parameter  int unsigned P_BPC     = 1,
    localparam int unsigned LP_CHK_W  = fn_ecc_synd_width(P_D_WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [P_D_WIDTH-1:0] data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [P_D_WIDTH-1:0] data_o,
    output logic [LP_CHK_W-1:0]  ecc_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned LP_M        = fn_field_order(P_D_WIDTH);
    localparam int unsigned LP_R        = 2 * LP_M;
    localparam int unsigned LP_STEPS    = (P_BPC == 0) ? 1 : (P_D_WIDTH / P_BPC);
    localparam int unsigned LP_CNT_W    = (LP_STEPS > 1) ? $clog2(LP_STEPS) : 1;
    localparam logic [16:0] LP_GEN      = fn_gen_poly(LP_M);
    localparam logic [LP_R-1:0] LP_G    = LP_GEN[LP_R-1:0];
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(LP_STEPS - 1);

    if (LP_M == 0) begin : gen_bad_width
        $error("bch_dec_enc_seq: P_D_WIDTH too large for field orders 5..8");
    end
    if ((P_BPC == 0) || ((P_D_WIDTH % P_BPC) != 0)) begin : gen_bad_bpc
        $error("bch_dec_enc_seq: P_BPC must divide P_D_WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [P_D_WIDTH-1:0]  shreg_q, shreg_d;
    logic [P_D_WIDTH-1:0]  data_q, data_d;
    logic [LP_R-1:0]       lfsr_q, lfsr_d;
    logic [LP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [LP_CHK_W-1:0]   ecc_q, ecc_d;
    logic                  out_valid_q, out_valid_d;

    logic [LP_R-1:0]       lfsr_step;
    logic                  fb;
`ifdef BCH_ENC_OVERALL_PAR_EN
    logic                  par_q, par_d;
    logic                  par_step;
`endif

    // Unrolled P_BPC single-bit LFSR steps, consuming shreg from its MSB downwards.
    always_comb begin
        lfsr_step = lfsr_q;
        fb        = 1'b0;
`ifdef BCH_ENC_OVERALL_PAR_EN
        par_step  = par_q;
`endif
        for (int b = 0; b < P_BPC; b++) begin
            fb        = lfsr_step[LP_R-1] ^ shreg_q[P_D_WIDTH-1-b];
            lfsr_step = {lfsr_step[LP_R-2:0], 1'b0} ^ (fb ? LP_G : '0);
`ifdef BCH_ENC_OVERALL_PAR_EN
            par_step  = par_step ^ shreg_q[P_D_WIDTH-1-b];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        ecc_d       = ecc_q;
        out_valid_d = out_valid_q;
`ifdef BCH_ENC_OVERALL_PAR_EN
        par_d       = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    shreg_d = data_i;
                    data_d  = data_i;
                    lfsr_d  = '0;
                    cnt_d   = '0;
`ifdef BCH_ENC_OVERALL_PAR_EN
                    par_d   = 1'b0;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                lfsr_d  = lfsr_step;
                shreg_d = shreg_q << P_BPC;
`ifdef BCH_ENC_OVERALL_PAR_EN
                par_d   = par_step;
`endif
                if (cnt_q == LP_CNT_LAST) begin
`ifdef BCH_ENC_OVERALL_PAR_EN
                    // Data parity so far plus parity of the final check bits.
                    ecc_d = {par_step ^ (^lfsr_step), lfsr_step};
`else
                    ecc_d = lfsr_step;
`endif
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + LP_CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            data_q      <= '0;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            ecc_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef BCH_ENC_OVERALL_PAR_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            ecc_q       <= ecc_d;
            out_valid_q <= out_valid_d;
`ifdef BCH_ENC_OVERALL_PAR_EN
            par_q       <= par_d;
`endif
        end
    end

    // Ready is masked combinationally so it reads 0 for the whole reset pulse.
    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q != StIdle);
    assign data_o      = data_q;
    assign ecc_o       = ecc_q;
    assign out_valid_o = out_valid_q;

endmodule
